enc_quad_gen: RTL
=================

# enc_quad_gen

Quadrature encoder emulator: generates A/B quadrature and once-per-revolution index signals from a programmable step period, line count and direction. Sits directly upstream of the digital-output function selector and drives its encoder inputs. Two instances per FPGA, one for each encoder channel set.

## Interface
- PERIOD_WIDTH, 16, width of step_period (xclk cycles per quadrature step)
- LINES_WIDTH, 16, width of lines_per_rev; position width is LINES_WIDTH+2
- xclk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  1 = run; 0 = freeze all state and outputs
- load  in  1  one-cycle strobe: capture step_period, lines_per_rev, direction
- step_period  in  PERIOD_WIDTH  xclk cycles between quadrature edges
- lines_per_rev  in  LINES_WIDTH  encoder lines per revolution
- direction  in  1  0 = forward (A leads B), 1 = reverse
- zero  in  1  one-cycle strobe: position to 0, quadrature state to S0
- enc_a  out  1  quadrature A
- enc_b  out  1  quadrature B
- enc_i  out  1  index; high while position == 0
- step_pulse  out  1  one-cycle strobe on every quadrature step
- position  out  LINES_WIDTH+2  current count within the revolution, 0..4*L-1

## Operation
- Config registers P (period), L (lines), D (direction); reset values P=2, L=1, D=0. On load: P ← max(step_period, 2), L ← max(lines_per_rev, 1), D ← direction.
- Quadrature FSM, states {A,B}: S0={0,0}, S1={1,0}, S2={1,1}, S3={0,1}. Forward: S0→S1→S2→S3→S0, position +1, wrapping 4L-1→0. Reverse: S0→S3→S2→S1→S0, position −1, wrapping 0→4L-1.
- Prescaler: while enable=1, it counts 0..P-1. At the cycle where prescaler==P-1, the prescaler returns to 0 and one step occurs (FSM, position, step_pulse=1).
- enable=0: prescaler, FSM and position hold; step_pulse=0. The outputs hold their last values.
- load: the prescaler clears to 0 and no step occurs that cycle. If position ≥ 4·L_new, position ← 0 and FSM ← S0. Otherwise position and FSM are kept.
- zero: position ← 0, FSM ← S0, prescaler ← 0, no step.
- Priority, highest first: reset, zero, load, step. When zero and load arrive together, load captures the config and zero sets position and FSM.
- enc_i is registered and equals (next position == 0). It is high for exactly P cycles per revolution in either direction.
- A full revolution equals 4L steps, which is 4·L·P cycles. The A and B periods are 4P cycles each.

## Timing
- Reset values: enc_a=0, enc_b=0, enc_i=1, step_pulse=0, position=0. Prescaler=0, FSM=S0.
- All outputs are registered. enc_a, enc_b, enc_i, position and step_pulse update on the same xclk edge as the step, with no further pipeline.
- First step: on the P-th rising edge with enable sampled high, counted from prescaler=0.
- After load or zero, the next step occurs P enabled cycles later.
- Direction changes take effect only through load. A reversal reverses the FSM from the current state with no skipped or duplicated state, so A/B never change on the same edge.
- Reset asserted mid-operation returns everything to reset values on the next edge, including the config registers.

## Test plan
- Reset, then load P=3, L=2, D=0, enable=1. Expected:
  - A/B sequence 00→10→11→01 with one edge every 3 cycles.
  - position counts 0..7 and wraps.
  - enc_i is high for 3 cycles every 24.
  - step_pulse occurs every 3 cycles.
- Reverse wrap: load D=1 at position 0. The next step gives position=7, state S3 (A=0, B=1), enc_i=0. Repeat with L=1 to check that 4L-1=3 wraps correctly.
- Load with step_period=0 and lines_per_rev=0. Expect clamping to P=2 and L=1: a step every 2 cycles and position cycling 0..3.
- At position 6 with L=2, load L=1. Expect position=0, S0, enc_i=1, and the next step 3 cycles later. Separately, load L=4 at position 6: position stays 6.
- Freeze and collisions:
  - Drop enable for 5 cycles mid-period. Outputs and position hold, and stepping resumes with the remaining prescaler count.
  - Assert zero and load together in the step cycle. No step occurs, position=0, and the new P is in effect.
- Assert reset for 1 cycle mid-revolution. On the next edge all outputs return to reset values and the config reverts to P=2, L=1, D=0.

Source files
------------

// File: rtl/enc_quad_gen.sv
// Quadrature encoder emulator: produces A/B quadrature, index and position
// from a programmable step period, line count and direction.
module enc_quad_gen #(
  parameter int PERIOD_WIDTH = 16,
  parameter int LINES_WIDTH  = 16
) (
  input  logic                    xclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] step_period,
  input  logic [LINES_WIDTH-1:0]  lines_per_rev,
  input  logic                    direction,
  input  logic                    zero,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    enc_i,
  output logic                    step_pulse,
  output logic [LINES_WIDTH+1:0]  position
);

  localparam int POS_W = LINES_WIDTH + 2;
  localparam logic [PERIOD_WIDTH-1:0] P_MIN = PERIOD_WIDTH'(2);
  localparam logic [LINES_WIDTH-1:0]  L_MIN = LINES_WIDTH'(1);

  // State encoding is {A,B}, so the outputs come straight off the register.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b10,
    S2 = 2'b11,
    S3 = 2'b01
  } quad_state_t;

  quad_state_t               state, state_next;
  logic [PERIOD_WIDTH-1:0]   p_reg, p_next;
  logic [LINES_WIDTH-1:0]    l_reg, l_next;
  logic                      d_reg, d_next;
  logic [PERIOD_WIDTH-1:0]   presc, presc_next;
  logic [POS_W-1:0]          pos_next;
  logic [POS_W-1:0]          four_l;
  logic [PERIOD_WIDTH-1:0]   p_clamped;
  logic [LINES_WIDTH-1:0]    l_clamped;
  logic                      step;

  assign four_l    = {l_reg, 2'b00};
  assign p_clamped = (step_period < P_MIN) ? P_MIN : step_period;
  assign l_clamped = (lines_per_rev == '0) ? L_MIN : lines_per_rev;

  assign enc_a = state[1];
  assign enc_b = state[0];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_next = state;
    p_next     = p_reg;
    l_next     = l_reg;
    d_next     = d_reg;
    presc_next = presc;
    pos_next   = position;
    step       = 1'b0;

    if (zero || load) begin
      // Zero and load both restart the period; load may also shrink the revolution.
      presc_next = '0;
      if (load) begin
        p_next = p_clamped;
        l_next = l_clamped;
        d_next = direction;
      end
      if (zero || (load && position >= {l_clamped, 2'b00})) begin
        pos_next   = '0;
        state_next = S0;
      end
    end else if (enable) begin
      if (presc == p_reg - 1'b1) begin
        presc_next = '0;
        step       = 1'b1;
        if (!d_reg) begin
          pos_next = (position == four_l - 1'b1) ? '0 : position + 1'b1;
          unique case (state)
            S0:      state_next = S1;
            S1:      state_next = S2;
            S2:      state_next = S3;
            default: state_next = S0;
          endcase
        end else begin
          pos_next = (position == '0) ? four_l - 1'b1 : position - 1'b1;
          unique case (state)
            S0:      state_next = S3;
            S3:      state_next = S2;
            S2:      state_next = S1;
            default: state_next = S0;
          endcase
        end
      end else begin
        presc_next = presc + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge xclk) begin
    if (!reset) begin
      state      <= S0;
      p_reg      <= P_MIN;
      l_reg      <= L_MIN;
      d_reg      <= 1'b0;
      presc      <= '0;
      position   <= '0;
      enc_i      <= 1'b1;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      p_reg      <= p_next;
      l_reg      <= l_next;
      d_reg      <= d_next;
      presc      <= presc_next;
      position   <= pos_next;
      enc_i      <= (pos_next == '0);
      step_pulse <= step;
    end
  end

endmodule
